// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state type, sizes and the round-robin pick function for the arbiter
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  typedef struct packed {
    logic found;
    logic [SEL_W-1:0] idx;
  } pick_t;
  // Scanning from the far end means the last hit is the one closest to ptr.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t p;
    logic [SEL_W-1:0] idx;
    p = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx = idx;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/mux4to1.sv
// mux4to1: selects one DATA_W lane out of four packed lanes
module mux4to1 #(
  parameter int DATA_W = 1
) (
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [1:0]          sel,
  output logic [DATA_W-1:0]   out_data
);
  assign out_data = in_data[sel*DATA_W +: DATA_W];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter owning the mux select, with a per-grant beat limit
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic                out_ready,
  output logic [3:0]          gnt,
  output logic [1:0]          sel,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                busy
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  state_t state, state_n;
  logic [3:0] gnt_n;
  logic [1:0] sel_n, ptr, ptr_n;
  logic [CW-1:0] count, count_n;
  logic [DATA_W-1:0] lane;
  logic beat, rel, arb;
  pick_t pick;
  mux4to1 #(.DATA_W(DATA_W)) u_mux (.in_data(in_data), .sel(sel), .out_data(lane));
  assign out_valid = (state == GRANT) && req[sel];
  assign out_data = out_valid ? lane : '0;
  assign busy = state == GRANT;
  assign beat = out_valid && out_ready;
  // A release re-arbitrates in the same edge from sel+1, so there is no idle bubble.
  always_comb begin
    rel = (state == GRANT) && (!req[sel] || (beat && count == CW'(MAX_HOLD - 1)));
    arb = (state == IDLE) || rel;
    ptr_n = rel ? sel + 2'd1 : ptr;
    pick = rr_pick(req, ptr_n);
    state_n = state;
    gnt_n = gnt;
    sel_n = sel;
    count_n = beat ? CW'(count + 1'b1) : count;
    if (arb) begin
      state_n = pick.found ? GRANT : IDLE;
      gnt_n = pick.found ? 4'b0001 << pick.idx : 4'b0000;
      sel_n = pick.found ? pick.idx : sel;
      count_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      ptr <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      sel <= sel_n;
      ptr <= ptr_n;
      count <= count_n;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and randomized checks of the arbiter against a grant-ownership model
module tb_mux4_rr_arbiter;
  localparam int DW = 4;
  localparam int MH = 4;
  logic clk = 0;
  logic reset, out_ready, out_valid, busy;
  logic [3:0] req, gnt;
  logic [1:0] sel;
  logic [4*DW-1:0] in_data;
  logic [DW-1:0] out_data;
  int ntests = 0, nfail = 0;
  int m_own = -1, m_ptr = 0, m_beats = 0, m_sel = 0;
  logic [15:0] lanes = 16'hA3C6;
  always #5 clk = ~clk;
  mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .in_data(in_data), .out_ready(out_ready),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  // Model: who owns the mux, how many beats it has moved, where the next scan starts.
  always @(posedge clk) begin
    logic r_s, y_s, v;
    logic [3:0] q_s;
    r_s = reset; q_s = req; y_s = out_ready;
    if (r_s) begin
      m_own = -1; m_ptr = 0; m_beats = 0; m_sel = 0;
    end else if (m_own < 0) begin
      m_own = first_from(q_s, m_ptr);
      m_beats = 0;
    end else begin
      v = q_s[m_own];
      if (v && y_s) m_beats++;
      if (!v || (v && y_s && m_beats == MH)) begin
        m_ptr = (m_own + 1) % 4;
        m_own = first_from(q_s, m_ptr);
        m_beats = 0;
      end
    end
    if (m_own >= 0) m_sel = m_own;
    #1;
    v = (m_own >= 0) && req[m_own];
    chk("gnt", gnt, m_own < 0 ? 0 : 1 << m_own);
    chk("sel", sel, m_sel);
    chk("busy", busy, m_own >= 0);
    chk("out_valid", out_valid, v);
    chk("out_data", out_data, v ? (in_data >> (DW * m_own)) & 4'hF : 0);
  end
  task automatic cyc(input logic [3:0] r, input logic rd, input logic rs);
    @(negedge clk);
    req = r; out_ready = rd; reset = rs;
    @(posedge clk);
    #2;
  endtask
  initial begin
    reset = 1; req = 0; out_ready = 0; in_data = 0;
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("rst_gnt", gnt, 0); chk("rst_sel", sel, 0); chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
    cyc(4'b0100, 1, 0); chk("mid_gnt", gnt, 4'b0100); chk("mid_busy", busy, 1);
    cyc(4'b0100, 1, 1); chk("mid_rst_gnt", gnt, 0); chk("mid_rst_sel", sel, 0);
    chk("mid_rst_valid", out_valid, 0); chk("mid_rst_busy", busy, 0);
    cyc(4'b0100, 1, 0); chk("mid_regnt", gnt, 4'b0100); chk("mid_regnt_sel", sel, 2);
    cyc(0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      cyc(4'b0011, 1, 0);
      chk("hold_gnt", gnt, (k < 4 || k >= 8) ? 4'b0001 : 4'b0010);
    end
    cyc(0, 1, 1);
    in_data = lanes;
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0010, 0, 0);
      chk("bp_gnt", gnt, 4'b0010); chk("bp_valid", out_valid, 1); chk("bp_data", out_data, 4'hC);
    end
    cyc(0, 1, 1);
    cyc(4'b0100, 1, 0); chk("wrap_g2", gnt, 4'b0100);
    cyc(4'b1000, 1, 0); chk("wrap_g3", gnt, 4'b1000);
    cyc(4'b1001, 1, 0); chk("wrap_b1", gnt, 4'b1000);
    cyc(4'b1001, 1, 0); chk("wrap_b2", gnt, 4'b1000);
    cyc(4'b0001, 1, 0); chk("wrap_gnt", gnt, 4'b0001); chk("wrap_sel", sel, 0);
    for (int s = 0; s < 4; s++) begin
      cyc(0, 1, 1);
      cyc(4'(1 << s), 1, 0);
      chk("route_sel", sel, s); chk("route_data", out_data, (lanes >> (4 * s)) & 16'hF);
      cyc(0, 1, 0);
      chk("idle_data", out_data, 0); chk("idle_valid", out_valid, 0); chk("idle_busy", busy, 0);
    end
    cyc(0, 1, 1);
    for (int k = 0; k < 20; k++) begin
      cyc(4'b1111, 1, 0);
      chk("rr_gnt", gnt, 1 << ((k / 4) % 4));
    end
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = $urandom_range(0, 149) == 0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      out_ready = $urandom_range(0, 3) != 0;
      in_data = 16'($urandom);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
